// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - processor-to-data-memory request/response bundle
interface dmem_responder_if;
  logic [1:0]  proc2Dmem_command;
  logic [31:0] proc2Dmem_addr;
  logic [31:0] proc2Dmem_data;
  logic [31:0] mem2proc_data;
  logic        mem2proc_valid;
  logic        mem2proc_err;
  logic [15:0] load_count;
  logic [15:0] store_count;

  modport master (
    output proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
    input  mem2proc_data, mem2proc_valid, mem2proc_err, load_count, store_count
  );

  modport slave (
    input  proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
    output mem2proc_data, mem2proc_valid, mem2proc_err, load_count, store_count
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word-addressed data memory with fixed-latency load responses
module dmem_responder #(
  parameter int DEPTH = 1024,
  parameter int LAT   = 1
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [1:0] BUS_LOAD  = 2'h1;
  localparam logic [1:0] BUS_STORE = 2'h2;

  logic [31:0]    mem_q [DEPTH];
  logic [AW-1:0]  idx;
  logic           in_range;
  logic           is_load;
  logic           is_store;
  logic [31:0]    rd_data;

  logic [LAT-1:0] vld_q;
  logic [LAT-1:0] perr_q;
  logic [31:0]    pdata_q [LAT];

  logic           st_err_q;
  logic           st_err_d;
  logic [15:0]    load_cnt_q;
  logic [15:0]    load_cnt_d;
  logic [15:0]    store_cnt_q;
  logic [15:0]    store_cnt_d;

  // Word index plus range/alignment qualification; reserved and idle commands decode to nothing.
  assign idx      = bus.proc2Dmem_addr[AW+1:2];
  assign in_range = (bus.proc2Dmem_addr[31:AW+2] == '0) && (bus.proc2Dmem_addr[1:0] == 2'b00);
  assign is_load  = (bus.proc2Dmem_command == BUS_LOAD);
  assign is_store = (bus.proc2Dmem_command == BUS_STORE);

  // Array write: in-range stores outside reset only; contents are never cleared so they survive rst.
  always_ff @(posedge clk) begin
    if (!rst && is_store && in_range) begin
      mem_q[idx] <= bus.proc2Dmem_data;
    end
  end

  // Combinational read of the word as it stands before this edge; bad loads return zero.
  always_comb begin
    rd_data = '0;
    if (in_range) begin
      rd_data = mem_q[idx];
    end
  end

  // LAT-deep response shift pipeline; stage 0 captures the load, the last stage drives the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      perr_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        pdata_q[i] <= '0;
      end
    end else begin
      vld_q[0]   <= is_load;
      perr_q[0]  <= is_load && !in_range;
      pdata_q[0] <= is_load ? rd_data : 32'h0;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i]   <= vld_q[i-1];
        perr_q[i]  <= perr_q[i-1];
        pdata_q[i] <= pdata_q[i-1];
      end
    end
  end

  // Next-state for the bad-store pulse and the saturating request counters.
  always_comb begin
    st_err_d    = is_store && !in_range;
    load_cnt_d  = load_cnt_q;
    store_cnt_d = store_cnt_q;
    if (is_load && (load_cnt_q != 16'hFFFF)) begin
      load_cnt_d = load_cnt_q + 16'd1;
    end
    if (is_store && (store_cnt_q != 16'hFFFF)) begin
      store_cnt_d = store_cnt_q + 16'd1;
    end
  end

  // Register the bad-store pulse and counters; reset discards any command presented with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_err_q    <= 1'b0;
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
    end else begin
      st_err_q    <= st_err_d;
      load_cnt_q  <= load_cnt_d;
      store_cnt_q <= store_cnt_d;
    end
  end

  // A bad-store pulse and a bad-load response landing together merge into one err cycle.
  assign bus.mem2proc_valid = vld_q[LAT-1];
  assign bus.mem2proc_data  = pdata_q[LAT-1];
  assign bus.mem2proc_err   = perr_q[LAT-1] | st_err_q;
  assign bus.load_count     = load_cnt_q;
  assign bus.store_count    = store_cnt_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder
module tb_dmem_responder;
  localparam int DEPTH = 1024;
  localparam int LAT   = 3;
  localparam int AW    = $clog2(DEPTH);

  typedef struct {
    logic [1:0]  c;
    logic [31:0] a;
    logic [31:0] d;
    logic        r;
  } op_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_responder_if bus ();
  dmem_responder #(.DEPTH(DEPTH), .LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total  = 0;
  int passed = 0;
  int cyc    = 0;

  // Reference: a plain word array, a ring of per-cycle expected responses, and two counts.
  logic [31:0] ref_mem [DEPTH];
  bit          sv [8];
  bit          se [8];
  logic [31:0] sd [8];
  int          lc = 0;
  int          sc = 0;
  bit          e_valid;
  bit          e_err;
  logic [31:0] e_data;
  op_t         ops [$];
  logic [31:0] got [$];

  function automatic bit addr_ok(input logic [31:0] a);
    return (a < 32'(DEPTH * 4)) && (a % 4 == 0);
  endfunction

  function automatic logic [31:0] rnd_addr();
    int k;
    k = $urandom_range(0, 9);
    if (k < 7) return 32'($urandom_range(0, DEPTH - 1)) * 4;
    if (k < 8) return 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
    return $urandom | (32'd1 << (AW + 2));
  endfunction

  function automatic void add(input logic [1:0] c, input logic [31:0] a, input logic [31:0] d, input logic r);
    op_t o;
    o.c = c; o.a = a; o.d = d; o.r = r;
    ops.push_back(o);
  endfunction

  task automatic step(input op_t o);
    int s;
    bus.proc2Dmem_command = o.c;
    bus.proc2Dmem_addr    = o.a;
    bus.proc2Dmem_data    = o.d;
    rst                   = o.r;
    @(posedge clk);
    cyc++;
    if (o.r) begin
      for (int i = 0; i < 8; i++) begin sv[i] = 0; se[i] = 0; sd[i] = '0; end
      lc = 0;
      sc = 0;
    end else if (o.c == 2'h1) begin
      s = (cyc + LAT - 1) % 8;
      sv[s] = 1;
      if (addr_ok(o.a)) sd[s] = ref_mem[o.a / 4];
      else begin sd[s] = '0; se[s] = 1; end
      if (lc < 65535) lc++;
    end else if (o.c == 2'h2) begin
      if (addr_ok(o.a)) ref_mem[o.a / 4] = o.d;
      else se[cyc % 8] = 1;
      if (sc < 65535) sc++;
    end
    #1;
    s = cyc % 8;
    e_valid = sv[s]; e_err = se[s]; e_data = sd[s];
    sv[s] = 0; se[s] = 0; sd[s] = '0;
    if (bus.mem2proc_valid === 1'b1) got.push_back(bus.mem2proc_data);
  endtask

  task automatic test_reset();
    ops.delete();
    add(2'h1, 32'h0, 32'h0, 1'b1);
    add(2'h2, 32'h4, 32'h1, 1'b1);
    add(2'h0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < ops.size(); i++) begin
      step(ops[i]);
      total++; if (bus.mem2proc_valid !== 1'b0) $display("FAIL reset_valid cyc=%0d got=%b exp=0", cyc, bus.mem2proc_valid); else passed++;
      total++; if (bus.mem2proc_err !== 1'b0) $display("FAIL reset_err cyc=%0d got=%b exp=0", cyc, bus.mem2proc_err); else passed++;
      total++; if (bus.mem2proc_data !== 32'h0) $display("FAIL reset_data cyc=%0d got=%h exp=0", cyc, bus.mem2proc_data); else passed++;
      total++; if (bus.load_count !== 16'h0) $display("FAIL reset_lcnt cyc=%0d got=%0d exp=0", cyc, bus.load_count); else passed++;
      total++; if (bus.store_count !== 16'h0) $display("FAIL reset_scnt cyc=%0d got=%0d exp=0", cyc, bus.store_count); else passed++;
    end
  endtask

  task automatic test_fill();
    ops.delete();
    for (int w = 0; w < DEPTH; w++) add(2'h2, 32'(w) * 4, $urandom, 1'b0);
    for (int i = 0; i < ops.size(); i++) begin
      step(ops[i]);
      total++; if (bus.mem2proc_valid !== e_valid) $display("FAIL fill_valid cyc=%0d got=%b exp=%b", cyc, bus.mem2proc_valid, e_valid); else passed++;
      total++; if (bus.mem2proc_err !== e_err) $display("FAIL fill_err cyc=%0d got=%b exp=%b", cyc, bus.mem2proc_err, e_err); else passed++;
    end
    total++; if (bus.store_count !== 16'(DEPTH)) $display("FAIL fill_scnt got=%0d exp=%0d", bus.store_count, DEPTH); else passed++;
  endtask

  // Directed scenarios: each entry also records the data values its valid cycles must carry.
  task automatic test_directed(input string nm, input int which);
    logic [31:0] want [$];
    ops.delete();
    got.delete();
    case (which)
      0: begin
        add(2'h2, 32'h10, 32'hCAFEBABE, 1'b0); add(2'h1, 32'h10, 32'h0, 1'b0);
        want = '{32'hCAFEBABE};
      end
      1: begin
        add(2'h2, 32'h0, 32'd1, 1'b0); add(2'h2, 32'h4, 32'd2, 1'b0); add(2'h2, 32'h8, 32'd3, 1'b0);
        add(2'h1, 32'h0, 32'h0, 1'b0); add(2'h1, 32'h4, 32'h0, 1'b0); add(2'h1, 32'h8, 32'h0, 1'b0);
        want = '{32'd1, 32'd2, 32'd3};
      end
      2: begin
        add(2'h2, 32'h20, 32'h55, 1'b0); add(2'h1, 32'h20, 32'h0, 1'b0);
        add(2'h2, 32'h20, 32'hAA, 1'b0); add(2'h1, 32'h20, 32'h0, 1'b0);
        want = '{32'h55, 32'hAA};
      end
      3: begin
        add(2'h2, 32'h24, 32'h77, 1'b0); add(2'h2, 32'h1000, 32'hDEAD, 1'b0);
        add(2'h1, 32'h2, 32'h0, 1'b0); add(2'h1, 32'h24, 32'h0, 1'b0);
        add(2'h1, 32'h1000, 32'h0, 1'b0); add(2'h0, 32'h0, 32'h0, 1'b0);
        add(2'h2, 32'h3, 32'h1, 1'b0);
        want = '{32'h0, 32'h77, 32'h0};
      end
      default: begin
        add(2'h2, 32'h40, 32'h12345678, 1'b0); add(2'h1, 32'h40, 32'h0, 1'b0);
        add(2'h0, 32'h0, 32'h0, 1'b0); add(2'h1, 32'h44, 32'h0, 1'b1);
        add(2'h2, 32'h40, 32'h0, 1'b1);
        for (int k = 0; k < 6; k++) add(2'h0, 32'h0, 32'h0, 1'b0);
        add(2'h1, 32'h40, 32'h0, 1'b0);
        want = '{32'h12345678};
      end
    endcase
    for (int k = 0; k < LAT + 1; k++) add(2'h0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < ops.size(); i++) begin
      step(ops[i]);
      total++; if (bus.mem2proc_valid !== e_valid) $display("FAIL %s_valid cyc=%0d got=%b exp=%b", nm, cyc, bus.mem2proc_valid, e_valid); else passed++;
      total++; if (bus.mem2proc_err !== e_err) $display("FAIL %s_err cyc=%0d got=%b exp=%b", nm, cyc, bus.mem2proc_err, e_err); else passed++;
      total++; if (bus.mem2proc_data !== e_data) $display("FAIL %s_data cyc=%0d got=%h exp=%h", nm, cyc, bus.mem2proc_data, e_data); else passed++;
      total++; if (bus.load_count !== 16'(lc)) $display("FAIL %s_lcnt cyc=%0d got=%0d exp=%0d", nm, cyc, bus.load_count, lc); else passed++;
      total++; if (bus.store_count !== 16'(sc)) $display("FAIL %s_scnt cyc=%0d got=%0d exp=%0d", nm, cyc, bus.store_count, sc); else passed++;
    end
    total++; if (got.size() != want.size()) $display("FAIL %s_resp_count got=%0d exp=%0d", nm, got.size(), want.size()); else passed++;
    for (int k = 0; k < want.size() && k < got.size(); k++) begin
      total++; if (got[k] !== want[k]) $display("FAIL %s_resp%0d got=%h exp=%h", nm, k, got[k], want[k]); else passed++;
    end
  endtask

  task automatic test_random(input string nm, input int n);
    op_t o;
    for (int i = 0; i < n; i++) begin
      o.c = 2'($urandom_range(0, 3)); o.a = rnd_addr(); o.d = $urandom;
      o.r = ($urandom_range(0, 199) == 0);
      step(o);
      total++; if (bus.mem2proc_valid !== e_valid) $display("FAIL %s_valid cyc=%0d got=%b exp=%b", nm, cyc, bus.mem2proc_valid, e_valid); else passed++;
      total++; if (bus.mem2proc_err !== e_err) $display("FAIL %s_err cyc=%0d got=%b exp=%b", nm, cyc, bus.mem2proc_err, e_err); else passed++;
      total++; if (bus.mem2proc_data !== e_data) $display("FAIL %s_data cyc=%0d got=%h exp=%h", nm, cyc, bus.mem2proc_data, e_data); else passed++;
      total++; if (bus.load_count !== 16'(lc)) $display("FAIL %s_lcnt cyc=%0d got=%0d exp=%0d", nm, cyc, bus.load_count, lc); else passed++;
      total++; if (bus.store_count !== 16'(sc)) $display("FAIL %s_scnt cyc=%0d got=%0d exp=%0d", nm, cyc, bus.store_count, sc); else passed++;
    end
  endtask

  task automatic test_saturation();
    op_t o;
    o.c = 2'h0; o.a = '0; o.d = '0; o.r = 1'b1;
    step(o);
    for (int i = 0; i < 65540; i++) begin
      o.c = 2'h1; o.a = 32'($urandom_range(0, DEPTH - 1)) * 4; o.r = 1'b0;
      step(o);
      total++; if (bus.mem2proc_valid !== e_valid) $display("FAIL sat_valid cyc=%0d got=%b exp=%b", cyc, bus.mem2proc_valid, e_valid); else passed++;
      total++; if (bus.mem2proc_data !== e_data) $display("FAIL sat_data cyc=%0d got=%h exp=%h", cyc, bus.mem2proc_data, e_data); else passed++;
      total++; if (bus.load_count !== 16'(lc)) $display("FAIL sat_lcnt cyc=%0d got=%0d exp=%0d", cyc, bus.load_count, lc); else passed++;
    end
    total++; if (bus.load_count !== 16'hFFFF) $display("FAIL sat_final got=%h exp=ffff", bus.load_count); else passed++;
    total++; if (bus.store_count !== 16'h0) $display("FAIL sat_scnt got=%0d exp=0", bus.store_count); else passed++;
  endtask

  initial begin
    bus.proc2Dmem_command = 2'h0;
    bus.proc2Dmem_addr    = 32'h0;
    bus.proc2Dmem_data    = 32'h0;
    for (int i = 0; i < 8; i++) begin sv[i] = 0; se[i] = 0; sd[i] = '0; end
    test_reset();
    test_fill();
    test_directed("round_trip", 0);
    test_directed("pipelined", 1);
    test_directed("collision", 2);
    test_directed("errors", 3);
    test_directed("reset_midflight", 4);
    test_random("random", 3000);
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
